mem_arbiter: RTL and testbench

Shares the single synchronous RAM port between instruction fetch (read-only) and the MEM stage (read/write), downstream of the EX/MEM register. It serializes accesses with a small FSM, gives MEM priority with a starvation bound for fetch, and returns per-requester stall and done signals so the pipeline freezes while its access is outstanding. All datapath outputs are registered. Stalls are derived combinationally from request and done.

---
 rtl/mem_arbiter_pkg.sv | 35 +++
 rtl/mem_arbiter_arb_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the RAM port arbiter.
//   Widths for the RAM word/address/byte-lane buses, the arbiter
//   state and owner encodings, and the request payload selected at grant.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W   = 30;
    localparam int unsigned SEL_W    = 4;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned STARVE_W = 4;
    localparam int unsigned LAT_W    = 3;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        ARB_OWNER_IF  = 1'b0,
        ARB_OWNER_MEM = 1'b1
    } arb_owner_t;

    // Access fields latched when a requester wins the port.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [SEL_W-1:0]  sel;
        logic [WORD_W-1:0] wdata;
    } ram_req_t;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational owner selection for the RAM port.
//   if_req      fetch request pending
//   mem_req     MEM stage read or write pending
//   starve_cnt  consecutive MEM grants taken while fetch was waiting
//   grant       some requester wants the port
//   owner       winner: MEM unless fetch has waited STARVE_LIMIT grants
module arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                if_req,
    input  logic                mem_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                grant,
    output arb_owner_t          owner
);

    always_comb begin
        grant = if_req | mem_req;
        owner = ARB_OWNER_IF;
        if (mem_req && ((starve_cnt < STARVE_W'(STARVE_LIMIT)) || !if_req)) begin
            owner = ARB_OWNER_MEM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one synchronous RAM port between instruction fetch (read
// only) and the MEM stage (read/write). MEM has priority, bounded by a
// starvation counter so fetch is served after STARVE_LIMIT MEM grants.
//   clk, rst                          clock, synchronous active-high reset
//   if_req/if_addr                    fetch request, held until if_done
//   if_rdata/if_done/if_stall         fetch result, completion pulse, stall
//   mem_re/mem_we/mem_addr/mem_sel/mem_wdata   MEM stage access
//   mem_rdata/mem_done/mem_stall      MEM result, completion pulse, stall
//   ram_ce/ram_we/ram_addr/ram_sel/ram_wdata   RAM strobe and fields (ISSUE only)
//   ram_rdata                         RAM read data, RAM_LATENCY after sampling
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned RAM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [SEL_W-1:0]  mem_sel,
    input  logic [WORD_W-1:0] mem_wdata,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              mem_stall,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [SEL_W-1:0]  ram_sel,
    output logic [WORD_W-1:0] ram_wdata,
    input  logic [WORD_W-1:0] ram_rdata
);

    arb_state_t          state;
    arb_owner_t          owner_q;
    logic [STARVE_W-1:0] starve_cnt;
    logic [LAT_W-1:0]    lat_cnt;

    logic       mem_req;
    logic       grant;
    arb_owner_t pick_owner;
    ram_req_t   pick_req;

    assign mem_req = mem_re | mem_we;

    // Pipeline freeze while the requester's access is still outstanding.
    assign if_stall  = if_req & ~if_done;
    assign mem_stall = mem_req & ~mem_done;

    arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .if_req     (if_req),
        .mem_req    (mem_req),
        .starve_cnt (starve_cnt),
        .grant      (grant),
        .owner      (pick_owner)
    );

    // Fields of the winning request; re+we together is handled as a write.
    always_comb begin
        pick_req = '0;
        if (pick_owner == ARB_OWNER_MEM) begin
            pick_req.we    = mem_we;
            pick_req.addr  = mem_addr;
            pick_req.sel   = mem_sel;
            pick_req.wdata = mem_wdata;
        end else begin
            pick_req.we    = 1'b0;
            pick_req.addr  = if_addr;
            pick_req.sel   = '1;
            pick_req.wdata = '0;
        end
    end

    // Arbiter FSM; the ram_* registers double as the latched request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner_q    <= ARB_OWNER_IF;
            starve_cnt <= '0;
            lat_cnt    <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_done    <= DISABLE;
            mem_done   <= DISABLE;
            ram_ce     <= DISABLE;
            ram_we     <= DISABLE;
            ram_addr   <= '0;
            ram_sel    <= '0;
            ram_wdata  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant) begin
                        owner_q   <= pick_owner;
                        ram_ce    <= ENABLE;
                        ram_we    <= pick_req.we;
                        ram_addr  <= pick_req.addr;
                        ram_sel   <= pick_req.sel;
                        ram_wdata <= pick_req.wdata;
                        if (pick_owner == ARB_OWNER_MEM) begin
                            // Count only grants that made fetch wait; saturate.
                            if (if_req && (starve_cnt != '1)) begin
                                starve_cnt <= starve_cnt + STARVE_W'(1);
                            end
                        end else begin
                            starve_cnt <= '0;
                        end
                        state <= ARB_ISSUE;
                    end
                end

                ARB_ISSUE: begin
                    ram_ce    <= DISABLE;
                    ram_we    <= DISABLE;
                    ram_addr  <= '0;
                    ram_sel   <= '0;
                    ram_wdata <= '0;
                    if (ram_we) begin
                        if (owner_q == ARB_OWNER_MEM) begin
                            mem_done <= ENABLE;
                        end else begin
                            if_done <= ENABLE;
                        end
                        state <= ARB_RESP;
                    end else begin
                        lat_cnt <= LAT_W'(RAM_LATENCY);
                        state   <= ARB_WAIT;
                    end
                end

                ARB_WAIT: begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                    // Last wait cycle: RAM data is valid now.
                    if (lat_cnt == LAT_W'(1)) begin
                        if (owner_q == ARB_OWNER_MEM) begin
                            mem_rdata <= ram_rdata;
                            mem_done  <= ENABLE;
                        end else begin
                            if_rdata <= ram_rdata;
                            if_done  <= ENABLE;
                        end
                        state <= ARB_RESP;
                    end
                end

                ARB_RESP: begin
                    if_done  <= DISABLE;
                    mem_done <= DISABLE;
                    state    <= ARB_IDLE;
                end

                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Instance u_dut: RAM_LATENCY=1, STARVE_LIMIT=2. Instance u_dut3: RAM_LATENCY=3.
// Inputs are driven and outputs sampled at the falling clock edge.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A (latency 1, starve limit 2)
    logic        if_req;
    logic [29:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done, if_stall;
    logic        mem_re, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_done, mem_stall;
    logic        ram_ce, ram_we;
    logic [29:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata, ram_rdata;

    // Instance B (latency 3)
    logic        b_if_req;
    logic [29:0] b_if_addr;
    logic [31:0] b_if_rdata;
    logic        b_if_done, b_if_stall;
    logic        b_mem_re, b_mem_we;
    logic [29:0] b_mem_addr;
    logic [3:0]  b_mem_sel;
    logic [31:0] b_mem_wdata, b_mem_rdata;
    logic        b_mem_done, b_mem_stall;
    logic        b_ram_ce, b_ram_we;
    logic [29:0] b_ram_addr;
    logic [3:0]  b_ram_sel;
    logic [31:0] b_ram_wdata, b_ram_rdata;

    mem_arbiter #(.RAM_LATENCY(1), .STARVE_LIMIT(2)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_stall(if_stall),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .mem_stall(mem_stall),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    mem_arbiter #(.RAM_LATENCY(3), .STARVE_LIMIT(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata),
        .if_done(b_if_done), .if_stall(b_if_stall),
        .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_sel(b_mem_sel),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_done(b_mem_done),
        .mem_stall(b_mem_stall),
        .ram_ce(b_ram_ce), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_sel(b_ram_sel),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
    );

    // RAM contents: two fixed words, otherwise a tag derived from the address.
    function automatic logic [31:0] ram_data(input logic [29:0] a);
        if (a == 30'h10) return 32'hDEAD_BEEF;
        if (a == 30'h30) return 32'h0000_0055;
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    // RAM models: data appears RAM_LATENCY edges after a sampled read, 0 otherwise.
    logic [31:0] b_pipe [3];
    always @(posedge clk) begin
        ram_rdata <= (ram_ce && !ram_we) ? ram_data(ram_addr) : 32'h0;
        b_pipe[0] <= (b_ram_ce && !b_ram_we) ? ram_data(b_ram_addr) : 32'h0;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_ram_rdata = b_pipe[2];

    task automatic test_reset();
        logic [133:0] regs;
        rst       = 1'b1;
        if_req    = 1'($urandom);
        if_addr   = 30'($urandom);
        mem_re    = 1'($urandom);
        mem_we    = 1'($urandom);
        mem_addr  = 30'($urandom);
        mem_sel   = 4'($urandom);
        mem_wdata = $urandom;
        b_if_req  = 1'($urandom);
        b_if_addr = 30'($urandom);
        @(negedge clk);
        @(negedge clk);
        regs = {if_rdata, mem_rdata, if_done, mem_done, ram_ce, ram_we,
                ram_addr, ram_sel, ram_wdata};
        checks++;
        if (regs !== 134'h0) begin
            errors++;
            $display("FAIL reset_regs: got %h expected 0", regs);
        end
        checks++;
        if ({b_if_done, b_mem_done, b_ram_ce, b_if_rdata} !== 35'h0) begin
            errors++;
            $display("FAIL reset_regs_b: got %h expected 0",
                     {b_if_done, b_mem_done, b_ram_ce, b_if_rdata});
        end
        checks++;
        if (if_stall !== if_req) begin
            errors++;
            $display("FAIL reset_if_stall: got %b expected %b", if_stall, if_req);
        end
        checks++;
        if (mem_stall !== (mem_re | mem_we)) begin
            errors++;
            $display("FAIL reset_mem_stall: got %b expected %b", mem_stall, mem_re | mem_we);
        end
        if_req = 1'b0; mem_re = 1'b0; mem_we = 1'b0; b_if_req = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ram_ce !== 1'b0 || b_ram_ce !== 1'b0) begin
                errors++;
                $display("FAIL idle_ram_ce[%0d]: got %b/%b expected 0/0", i, ram_ce, b_ram_ce);
            end
        end
    endtask

    task automatic test_fetch_read();
        if_req  = 1'b1;
        if_addr = 30'h10;
        #1;
        checks++;
        if (if_stall !== 1'b1) begin
            errors++;
            $display("FAIL fetch_stall_n0: got %b expected 1", if_stall);
        end
        @(negedge clk);
        checks++;
        if (ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 30'h10 || if_stall !== 1'b1) begin
            errors++;
            $display("FAIL fetch_issue: ce=%b we=%b addr=%h stall=%b expected 1 0 10 1",
                     ram_ce, ram_we, ram_addr, if_stall);
        end
        @(negedge clk);
        checks++;
        if (if_done !== 1'b0 || if_stall !== 1'b1 || ram_ce !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait: done=%b stall=%b ce=%b expected 0 1 0",
                     if_done, if_stall, ram_ce);
        end
        @(negedge clk);
        checks++;
        if (if_done !== 1'b1 || if_rdata !== 32'hDEAD_BEEF || if_stall !== 1'b0) begin
            errors++;
            $display("FAIL fetch_done: done=%b data=%h stall=%b expected 1 deadbeef 0",
                     if_done, if_rdata, if_stall);
        end
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (if_done !== 1'b0 || if_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL fetch_after: done=%b data=%h expected 0 deadbeef", if_done, if_rdata);
        end
    endtask

    task automatic test_store();
        logic [29:0] addrs [2];
        logic [3:0]  sels  [2];
        logic [31:0] datas [2];
        addrs[0] = 30'h20; sels[0] = 4'b0011; datas[0] = 32'h0000_1234;
        addrs[1] = 30'h24; sels[1] = 4'b0000; datas[1] = 32'hFFFF_0000;
        for (int i = 0; i < 2; i++) begin
            mem_we = 1'b1; mem_re = 1'b0;
            mem_addr = addrs[i]; mem_sel = sels[i]; mem_wdata = datas[i];
            #1;
            checks++;
            if (mem_stall !== 1'b1) begin
                errors++;
                $display("FAIL store%0d_stall: got %b expected 1", i, mem_stall);
            end
            @(negedge clk);
            checks++;
            if (ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_addr !== addrs[i] ||
                ram_sel !== sels[i] || ram_wdata !== datas[i]) begin
                errors++;
                $display("FAIL store%0d_issue: ce=%b we=%b addr=%h sel=%b wdata=%h expected 1 1 %h %b %h",
                         i, ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
                         addrs[i], sels[i], datas[i]);
            end
            @(negedge clk);
            checks++;
            if (mem_done !== 1'b1 || mem_stall !== 1'b0 || ram_ce !== 1'b0) begin
                errors++;
                $display("FAIL store%0d_done: done=%b stall=%b ce=%b expected 1 0 0",
                         i, mem_done, mem_stall, ram_ce);
            end
            mem_we = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_read_write();
        mem_re = 1'b1; mem_we = 1'b0; mem_addr = 30'h30; mem_sel = 4'hF;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_done !== 1'b1 || mem_rdata !== 32'h55) begin
            errors++;
            $display("FAIL load_55: done=%b data=%h expected 1 00000055", mem_done, mem_rdata);
        end
        mem_re = 1'b0;
        @(negedge clk);
        mem_re = 1'b1; mem_we = 1'b1; mem_wdata = 32'hAA;
        @(negedge clk);
        checks++;
        if (ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_wdata !== 32'hAA) begin
            errors++;
            $display("FAIL rw_issue: ce=%b we=%b wdata=%h expected 1 1 000000aa",
                     ram_ce, ram_we, ram_wdata);
        end
        @(negedge clk);
        checks++;
        if (mem_done !== 1'b1 || mem_rdata !== 32'h55) begin
            errors++;
            $display("FAIL rw_done: done=%b data=%h expected 1 00000055", mem_done, mem_rdata);
        end
        mem_re = 1'b0; mem_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [29:0] got [4];
        logic [29:0] exp_addr [4];
        int grants = 0;
        int mdone = 0;
        int idone = 0;
        int if_after = -1;
        bit finished = 1'b0;
        exp_addr[0] = 30'h80; exp_addr[1] = 30'h84;
        exp_addr[2] = 30'h40; exp_addr[3] = 30'h88;
        for (int i = 0; i < 4; i++) got[i] = '0;
        if_req = 1'b1; if_addr = 30'h40;
        mem_re = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 30'h80;
        for (int c = 0; c < 60 && !finished; c++) begin
            @(negedge clk);
            if (ram_ce) begin
                if (grants < 4) got[grants] = ram_addr;
                grants++;
            end
            if (mem_done) begin
                mdone++;
                if (mdone >= 3) mem_re = 1'b0;
                else mem_addr = mem_addr + 30'h4;
            end
            if (if_done) begin
                idone++;
                if_after = mdone;
                if_req = 1'b0;
            end
            if (mdone >= 3 && idone >= 1) finished = 1'b1;
        end
        if_req = 1'b0; mem_re = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL contention_timeout: mem_done=%0d if_done=%0d expected 3 1", mdone, idone);
        end
        checks++;
        if (grants != 4) begin
            errors++;
            $display("FAIL contention_grants: got %0d expected 4", grants);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp_addr[i]) begin
                errors++;
                $display("FAIL contention_grant%0d: addr %h expected %h", i, got[i], exp_addr[i]);
            end
        end
        checks++;
        if (idone != 1 || if_after != 2) begin
            errors++;
            $display("FAIL contention_if_done: pulses=%0d after_mem_done=%0d expected 1 2",
                     idone, if_after);
        end
        checks++;
        if (if_rdata !== 32'hC0DE_0040 || mem_rdata !== 32'hC0DE_0088) begin
            errors++;
            $display("FAIL contention_data: if=%h mem=%h expected c0de0040 c0de0088",
                     if_rdata, mem_rdata);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        b_if_req = 1'b1; b_if_addr = 30'h10;
        @(negedge clk);
        checks++;
        if (b_ram_ce !== 1'b1 || b_ram_addr !== 30'h10) begin
            errors++;
            $display("FAIL midrst_issue: ce=%b addr=%h expected 1 10", b_ram_ce, b_ram_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (b_if_done !== 1'b0 || b_ram_ce !== 1'b0 || b_if_stall !== 1'b1 ||
            b_if_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midrst_abort: done=%b ce=%b stall=%b data=%h expected 0 0 1 0",
                     b_if_done, b_ram_ce, b_if_stall, b_if_rdata);
        end
        rst = 1'b0;
        b_if_addr = 30'h14;
        @(negedge clk);
        checks++;
        if (b_ram_ce !== 1'b1 || b_ram_addr !== 30'h14) begin
            errors++;
            $display("FAIL midrst_reissue: ce=%b addr=%h expected 1 14", b_ram_ce, b_ram_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (b_if_done !== 1'b0) begin
                errors++;
                $display("FAIL midrst_wait%0d: done=%b expected 0", i, b_if_done);
            end
        end
        @(negedge clk);
        checks++;
        if (b_if_done !== 1'b1 || b_if_rdata !== 32'hC0DE_0014) begin
            errors++;
            $display("FAIL midrst_done: done=%b data=%h expected 1 c0de0014",
                     b_if_done, b_if_rdata);
        end
        b_if_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        mem_re = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_sel = '0; mem_wdata = '0;
        b_if_req = 1'b0; b_if_addr = '0;
        b_mem_re = 1'b0; b_mem_we = 1'b0; b_mem_addr = '0; b_mem_sel = '0; b_mem_wdata = '0;

        test_reset();
        test_fetch_read();
        test_store();
        test_read_write();
        test_contention();
        test_reset_mid_read();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
